dsp_mac_sequencer: RTL

Controller that runs dot-product (multiply-accumulate) jobs on one dsp48a1 slice. It accepts signed 18x18 operand pairs on a valid/ready stream, with `s_last` marking the end of each job. It drives the slice's A/B/OPMODE/clock-enable inputs and tracks every beat through the slice pipeline. When a job's last product has been accumulated, it returns the 48-bit P as a held result. It sits beside the dsp48a1 instance in the parent, with the parent wiring the `dsp_*` ports straight through.

---
 rtl/dsp_seq_pkg.sv | 26 ++
 rtl/dsp_seq_tagpipe.sv | 39 +++
 rtl/dsp_mac_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the dsp48a1 MAC sequencer.
// DSP_SEQ_CNT_EN adds a 16-bit beat count to every tag.
package dsp_seq_pkg;

  localparam int LAT     = 3;
  localparam int OPM_LAG = 2;

  // X=M, Z=0 starts a new sum; X=M, Z=P keeps accumulating.
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        first;
    logic        last;
`ifdef DSP_SEQ_CNT_EN
    logic [15:0] count;
`endif
  } tag_t;

endpackage

// File: rtl/dsp_seq_tagpipe.sv
// Enabled shift register of beat tags that mirrors the dsp48a1 pipeline.
// Stage 0 is loaded from din; every stage is visible on the stages output.
module dsp_seq_tagpipe
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = LAT + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  tag_t din,
  output tag_t stages [DEPTH]
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      tag_t prev;
      tag_t stage_reg;

      if (gi == 0) begin : g_head
        assign prev = din;
      end else begin : g_body
        assign prev = stages[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_reg <= '0;
        end else if (en) begin
          stage_reg <= prev;
        end
      end

      assign stages[gi] = stage_reg;
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one dsp48a1 slice through dot-product jobs and returns the held sum.
// DSP_SEQ_CNT_EN enables the per-job beat count on m_count.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [47:0] m_data,
  output logic [15:0] m_count,
  output logic [17:0] dsp_A,
  output logic [17:0] dsp_B,
  output logic [7:0]  dsp_OPMODE,
  output logic        dsp_CE,
  input  logic [47:0] dsp_P
);

  state_t      state_reg, state_next;
  tag_t        tag_next;
  tag_t        stages [LAT+1];
  logic        stall;
  logic        accept;
  logic        capture;
  logic        m_valid_reg;
  logic [47:0] m_data_reg;
  logic [17:0] dsp_a_reg, dsp_b_reg;

  // A pending, unconsumed result freezes the slice and the tag pipe together.
  assign stall   = m_valid_reg && !m_ready;
  assign s_ready = !stall;
  assign dsp_CE  = !stall;
  assign accept  = s_valid && s_ready;
  assign capture = stages[LAT].valid && stages[LAT].last && !stall;

`ifdef DSP_SEQ_CNT_EN
  logic [15:0] beat_cnt_reg, beat_cnt_next;
  logic [15:0] m_count_reg;

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (state_reg == IDLE) begin
      beat_cnt_next = 16'd1;
    end else if (beat_cnt_reg != 16'hFFFF) begin
      beat_cnt_next = beat_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg <= '0;
      m_count_reg  <= '0;
    end else begin
      if (accept) beat_cnt_reg <= beat_cnt_next;
      if (capture) m_count_reg <= stages[LAT].count;
    end
  end

  assign m_count = m_count_reg;
`else
  assign m_count = '0;
`endif

  always_comb begin
    state_next = state_reg;
    tag_next   = '0;
    if (accept) begin
      tag_next.valid = 1'b1;
      tag_next.first = (state_reg == IDLE);
      tag_next.last  = s_last;
`ifdef DSP_SEQ_CNT_EN
      tag_next.count = beat_cnt_next;
`endif
      state_next     = s_last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Idle cycles push zero operands so bubbles add M=0 to the running sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_a_reg <= '0;
      dsp_b_reg <= '0;
    end else if (dsp_CE) begin
      dsp_a_reg <= accept ? s_a : 18'd0;
      dsp_b_reg <= accept ? s_b : 18'd0;
    end
  end

  assign dsp_A = dsp_a_reg;
  assign dsp_B = dsp_b_reg;

  dsp_seq_tagpipe #(
    .DEPTH (LAT + 1)
  ) u_tagpipe (
    .clk    (clk),
    .rst    (rst),
    .en     (dsp_CE),
    .din    (tag_next),
    .stages (stages)
  );

  assign dsp_OPMODE = stages[OPM_LAG].first ? OPM_LOAD : OPM_ACC;

  // A capture on the same edge as a consume keeps m_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else if (capture) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= dsp_P;
    end else if (m_ready) begin
      m_valid_reg <= 1'b0;
    end
  end

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;

endmodule
